conbus_wdt: RTL and testbench
=============================

Name: conbus_wdt

Overview:
Wishbone bus watchdog inserted between one conbus slave port and its slave. It passes all cycles through unchanged. If a strobed cycle goes unacknowledged for TIMEOUT cycles, it acks the master itself with ERR_DATA, aborts the slave cycle, and logs the fault. This stops a dead peripheral from locking the shared bus and starving all five masters.

Parameters:
TIMEOUT, 1024, wait cycles tolerated per beat before forced ack (≥2)
ERR_DATA, 32'hdeadbeef, read data returned on a forced ack
ERRCNT_W, 8, width of the saturating timeout counter

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
enable_i  in  1  watchdog enable; 0 = pure passthrough, counter held at 0
err_clr_i  in  1  clears err_count_o and err_sticky_o
m_dat_i/m_adr_i  in  32/32  write data / address from conbus slave port
m_cti_i  in  3  cycle type
m_sel_i  in  4  byte select
m_we_i, m_cyc_i, m_stb_i  in  1 each  Wishbone control from conbus
m_dat_o  out  32  read data to conbus
m_ack_o  out  1  ack to conbus
s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  32/32/3/4/1/1/1  to slave
s_dat_i  in  32  slave read data
s_ack_i  in  1  slave ack
timeout_o  out  1  one-cycle pulse, registered, on the cycle after a forced ack
err_sticky_o  out  1  set by any timeout
err_adr_o  out  32  address of the most recent timed-out cycle
err_count_o  out  ERRCNT_W  timeouts since clear; saturates at all-ones

Behaviour:
- Reset (sync): state IDLE; wait counter 0; timeout_o, err_sticky_o = 0; err_adr_o, err_count_o = 0.
- Passthrough is combinational, zero latency:
  - s_dat/adr/cti/sel/we_o follow the m_* inputs.
  - s_cyc_o = m_cyc_i and s_stb_o = m_stb_i, except in ABORT.
- Active beat: req = m_cyc_i & m_stb_i.
- State IDLE:
  - req & !s_ack_i & enable_i → WAIT, counter ← 1.
  - Otherwise stay in IDLE, counter 0.
- State WAIT:
  - s_ack_i → IDLE, counter ← 0 (per-beat restart; each burst beat gets a fresh TIMEOUT).
  - !req (master withdrew stb or cyc) → IDLE, counter ← 0, no error.
  - !enable_i → IDLE, counter ← 0.
  - req & !s_ack_i & counter == TIMEOUT: forced-ack cycle.
    - m_ack_o = 1, m_dat_o = ERR_DATA.
    - err_adr_o ← m_adr_i, err_sticky_o ← 1, err_count_o ← +1 (saturating).
    - timeout_o = 1 next cycle; → ABORT.
  - Otherwise counter ← counter+1.
- Forced-ack timing: strobe first seen at cycle 0 → forced ack at cycle TIMEOUT.
- State ABORT (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0; m_ack_o = 0; s_ack_i ignored (a late slave ack is swallowed); → IDLE.
  - If the master still holds req, the next beat starts in IDLE normally.
- m_ack_o = s_ack_i in IDLE/WAIT (forced ack ORed in); 0 in ABORT.
- m_dat_o = s_dat_i except in the forced-ack cycle.
- Simultaneous events:
  - s_ack_i on the cycle counter == TIMEOUT: the slave wins; normal ack, no error logged.
  - err_clr_i with a forced ack in the same cycle: timeout wins; err_count_o = 1, err_sticky_o = 1.
- Counter width: enough bits to hold TIMEOUT; it never wraps, because it stops at TIMEOUT.
- Reset mid-cycle: the FSM returns to IDLE and no ack is generated. Passthrough resumes immediately, so a still-pending master cycle is re-timed from 0.

Decomposition:
- Shared package conbus_pkg holds:
  - the 2-bit state encodings (IDLE=0, WAIT=1, ABORT=2);
  - the default ERR_DATA constant;
  - the Wishbone CTI constants (classic 3'b000, end-of-burst 3'b111).
- No sub-module; the counter and FSM are small enough to live in one block.

Test Plan:
- TIMEOUT=4; slave acks 2 cycles after stb → m_ack_o on cycle 2 with slave data; err_count_o stays 0; timeout_o never pulses.
- TIMEOUT=4; slave never acks; stb at cycle 0, m_adr_i=32'h6000_0010 → forced ack at cycle 4 with m_dat_o=32'hdeadbeef; cycle 5: timeout_o=1, s_cyc_o=0; err_adr_o=32'h6000_0010; err_count_o=1.
- Slave acks exactly at cycle 4 (TIMEOUT=4) → normal ack with slave data; err_sticky_o=0; then a late s_ack_i injected during ABORT after a real timeout → no m_ack_o.
- 4-beat burst (cti=3'b010), slave waits 3 cycles per beat with TIMEOUT=4 → all 4 beats complete normally; counter restarts on each beat.
- 300 consecutive timeouts → err_count_o saturates at 8'hff; err_clr_i asserted in the same cycle as a forced ack → err_count_o=1; enable_i=0 with a hung slave → no ack for 2000 cycles.
- sys_rst asserted in WAIT at counter=3 → next cycle state IDLE, no forced ack; the master's held stb is timed again from 0 (forced ack at cycle 4 after reset release).

Source files
------------

// File: rtl/conbus_pkg.sv
// Shared conbus definitions: watchdog FSM encoding, default error read data
// and the Wishbone cycle-type codes.
package conbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } wdt_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/conbus_wdt.sv
// Wishbone watchdog between a conbus slave port and its slave: forwards every
// cycle untouched, but force-acks and aborts a beat the slave leaves hanging.
module conbus_wdt
  import conbus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable_i,
  input  logic                err_clr_i,
  input  logic [31:0]         m_dat_i,
  input  logic [31:0]         m_adr_i,
  input  logic [2:0]          m_cti_i,
  input  logic [3:0]          m_sel_i,
  input  logic                m_we_i,
  input  logic                m_cyc_i,
  input  logic                m_stb_i,
  output logic [31:0]         m_dat_o,
  output logic                m_ack_o,
  output logic [31:0]         s_dat_o,
  output logic [31:0]         s_adr_o,
  output logic [2:0]          s_cti_o,
  output logic [3:0]          s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic [31:0]         s_dat_i,
  input  logic                s_ack_i,
  output logic                timeout_o,
  output logic                err_sticky_o,
  output logic [31:0]         err_adr_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LIMIT = cnt_t'(TIMEOUT);

  wdt_state_e            state_q, state_d;
  cnt_t                  waitCnt_q, waitCnt_d;
  logic                  timeout_q, timeout_d;
  logic                  errSticky_q, errSticky_d;
  logic [31:0]           errAdr_q, errAdr_d;
  logic [ERRCNT_W-1:0]   errCount_q, errCount_d;
  logic                  req;
  logic                  inAbort;
  logic                  forceAck;

  assign req     = m_cyc_i & m_stb_i;
  assign inAbort = (state_q == ST_ABORT);

  // A slave ack on the limit cycle wins, and a reset cycle never forces an ack.
  assign forceAck = (state_q == ST_WAIT) && req && !s_ack_i && enable_i &&
                    (waitCnt_q == CNT_LIMIT) && !sys_rst;

  assign s_dat_o = m_dat_i;
  assign s_adr_o = m_adr_i;
  assign s_cti_o = m_cti_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
  assign s_cyc_o = m_cyc_i & ~inAbort;
  assign s_stb_o = m_stb_i & ~inAbort;

  assign m_ack_o = ~inAbort & (s_ack_i | forceAck);
  assign m_dat_o = forceAck ? ERR_DATA : s_dat_i;

  assign timeout_o    = timeout_q;
  assign err_sticky_o = errSticky_q;
  assign err_adr_o    = errAdr_q;
  assign err_count_o  = errCount_q;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !s_ack_i && enable_i) begin
          state_d   = ST_WAIT;
          waitCnt_d = cnt_t'(1);
        end else begin
          waitCnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (s_ack_i || !req || !enable_i) begin
          state_d   = ST_IDLE;
          waitCnt_d = '0;
        end else if (waitCnt_q == CNT_LIMIT) begin
          state_d   = ST_ABORT;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        state_d   = ST_IDLE;
        waitCnt_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  // A timeout in the same cycle as a clear restarts the log at one fault.
  always_comb begin
    timeout_d   = forceAck;
    errSticky_d = errSticky_q;
    errAdr_d    = errAdr_q;
    errCount_d  = errCount_q;
    if (forceAck) begin
      errSticky_d = 1'b1;
      errAdr_d    = m_adr_i;
      if (err_clr_i) begin
        errCount_d = ERRCNT_W'(1);
      end else if (errCount_q != {ERRCNT_W{1'b1}}) begin
        errCount_d = errCount_q + 1'b1;
      end
    end else if (err_clr_i) begin
      errSticky_d = 1'b0;
      errCount_d  = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      waitCnt_q   <= '0;
      timeout_q   <= 1'b0;
      errSticky_q <= 1'b0;
      errAdr_q    <= '0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      timeout_q   <= timeout_d;
      errSticky_q <= errSticky_d;
      errAdr_q    <= errAdr_d;
      errCount_q  <= errCount_d;
    end
  end

endmodule

// File: tb/tb_conbus_wdt.sv
// Bench for conbus_wdt: hand-written vector table, directed corner sequences
// and random traffic, all checked against a timestamp-based reference model.
module tb_conbus_wdt;
  import conbus_pkg::*;

  localparam int TIMEOUT = 4;
  localparam logic [31:0] ERR = 32'hdeadbeef;

  logic        sys_clk, sys_rst, enable_i, err_clr_i;
  logic [31:0] m_dat_i, m_adr_i, s_dat_i;
  logic [2:0]  m_cti_i;
  logic [3:0]  m_sel_i;
  logic        m_we_i, m_cyc_i, m_stb_i, s_ack_i;
  logic [31:0] m_dat_o, s_dat_o, s_adr_o, err_adr_o;
  logic        m_ack_o, s_we_o, s_cyc_o, s_stb_o, timeout_o, err_sticky_o;
  logic [2:0]  s_cti_o;
  logic [3:0]  s_sel_o;
  logic [7:0]  err_count_o;

  conbus_wdt #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR), .ERRCNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable_i(enable_i), .err_clr_i(err_clr_i),
    .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .timeout_o(timeout_o), .err_sticky_o(err_sticky_o),
    .err_adr_o(err_adr_o), .err_count_o(err_count_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst, en, clr, cyc, stb, we, sack;
    logic [2:0]  cti;
    logic [3:0]  sel;
    logic [31:0] adr, mdat, sdat;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        expAck;
    logic [31:0] expDat;
    logic        expScyc, expTo, expSticky;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t tbl[$];

  int compared, mismatched;

  // Reference model: a beat is remembered by the cycle it started in, and an
  // abort by the cycle it occupies; forced acks fall out of the elapsed time.
  int          cycleNo, beatStart, abortCycle;
  bit          mTimeout, mSticky;
  int          mCount;
  logic [31:0] mAdr;

  logic        obsAck, obsScyc, obsTo, obsSticky;
  logic [31:0] obsDat;
  logic [7:0]  obsCount;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNo, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic rst, input logic en, input logic clr,
                               input logic cyc, input logic stb, input logic sack,
                               input logic [31:0] adr, input logic [31:0] sdat);
    stim_t s;
    s.rst = rst; s.en = en; s.clr = clr; s.cyc = cyc; s.stb = stb; s.sack = sack;
    s.we = adr[2]; s.cti = CTI_CLASSIC; s.sel = 4'hf;
    s.adr = adr; s.mdat = ~adr; s.sdat = sdat;
    return s;
  endfunction

  function void addRow(input stim_t s, input logic a, input logic [31:0] d, input logic c,
                       input logic t, input logic st, input logic [7:0] n);
    tbl.push_back('{s, a, d, c, t, st, n});
  endfunction

  task automatic applyStimulus(input stim_t s);
    bit inAbort, forced, req;
    sys_rst = s.rst; enable_i = s.en; err_clr_i = s.clr;
    m_cyc_i = s.cyc; m_stb_i = s.stb; m_we_i = s.we; m_cti_i = s.cti; m_sel_i = s.sel;
    m_adr_i = s.adr; m_dat_i = s.mdat; s_dat_i = s.sdat; s_ack_i = s.sack;
    #3;
    req     = s.cyc && s.stb;
    inAbort = (cycleNo == abortCycle);
    forced  = !s.rst && !inAbort && (beatStart >= 0) && req && !s.sack && s.en &&
              (cycleNo - beatStart == TIMEOUT);
    obsAck = m_ack_o; obsDat = m_dat_o; obsScyc = s_cyc_o;
    obsTo = timeout_o; obsSticky = err_sticky_o; obsCount = err_count_o;
    checkOutput("m_ack_o", m_ack_o, !inAbort && (s.sack || forced));
    checkOutput("m_dat_o", m_dat_o, forced ? ERR : s.sdat);
    checkOutput("s_cyc_o", s_cyc_o, s.cyc && !inAbort);
    checkOutput("s_stb_o", s_stb_o, s.stb && !inAbort);
    checkOutput("s_adr_o", s_adr_o, s.adr);
    checkOutput("s_dat_o", s_dat_o, s.mdat);
    checkOutput("s_ctl_o", {s_cti_o, s_sel_o, s_we_o}, {s.cti, s.sel, s.we});
    checkOutput("timeout_o", timeout_o, mTimeout);
    checkOutput("err_sticky_o", err_sticky_o, mSticky);
    checkOutput("err_count_o", err_count_o, mCount);
    checkOutput("err_adr_o", err_adr_o, mAdr);
    if (s.rst) begin
      beatStart = -1; abortCycle = -1;
      mTimeout = 0; mSticky = 0; mCount = 0; mAdr = '0;
    end else begin
      mTimeout = forced;
      if (forced) begin
        mSticky = 1; mAdr = s.adr;
        mCount = s.clr ? 1 : ((mCount == 255) ? 255 : mCount + 1);
        abortCycle = cycleNo + 1; beatStart = -1;
      end else begin
        if (s.clr) begin mCount = 0; mSticky = 0; end
        if (inAbort) beatStart = -1;
        else if (beatStart < 0) begin
          if (req && !s.sack && s.en) beatStart = cycleNo;
        end else if (s.sack || !req || !s.en) beatStart = -1;
      end
    end
    cycleNo++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic buildTable();
    stim_t idle;
    idle = mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    addRow(mk(1, 1, 0, 0, 0, 0, 32'h0, 32'h0), 0, 32'h0, 0, 0, 0, 0);
    // Slave acks two cycles after the strobe.
    addRow(mk(0, 1, 0, 1, 1, 0, 32'h1000_0000, 32'haaaa0001), 0, 32'haaaa0001, 1, 0, 0, 0);
    addRow(mk(0, 1, 0, 1, 1, 0, 32'h1000_0000, 32'haaaa0002), 0, 32'haaaa0002, 1, 0, 0, 0);
    addRow(mk(0, 1, 0, 1, 1, 1, 32'h1000_0000, 32'haaaa0003), 1, 32'haaaa0003, 1, 0, 0, 0);
    addRow(idle, 0, 32'h0, 0, 0, 0, 0);
    // Slave acks exactly on the limit cycle and must win.
    for (int k = 0; k < TIMEOUT; k++)
      addRow(mk(0, 1, 0, 1, 1, 0, 32'h2000_0004, 32'hbbbb0000 + k), 0, 32'hbbbb0000 + k, 1, 0, 0, 0);
    addRow(mk(0, 1, 0, 1, 1, 1, 32'h2000_0004, 32'hbbbb0004), 1, 32'hbbbb0004, 1, 0, 0, 0);
    addRow(idle, 0, 32'h0, 0, 0, 0, 0);
    // Hung slave: forced ack on cycle 4, then an abort cycle that swallows a late ack.
    for (int k = 0; k < TIMEOUT; k++)
      addRow(mk(0, 1, 0, 1, 1, 0, 32'h6000_0010, 32'hcccc0000 + k), 0, 32'hcccc0000 + k, 1, 0, 0, 0);
    addRow(mk(0, 1, 0, 1, 1, 0, 32'h6000_0010, 32'hcccc0004), 1, ERR, 1, 0, 0, 0);
    addRow(mk(0, 1, 0, 1, 1, 1, 32'h6000_0010, 32'hcccc0005), 0, 32'hcccc0005, 0, 1, 1, 1);
    addRow(idle, 0, 32'h0, 0, 0, 1, 1);
    addRow(mk(0, 1, 1, 0, 0, 0, 32'h0, 32'h0), 0, 32'h0, 0, 0, 1, 1);
    addRow(idle, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    stim_t s;
    int acks, toSeen, forcedSeen, ackAt;
    logic holdReq;
    compared = 0; mismatched = 0;
    cycleNo = 0; beatStart = -1; abortCycle = -1;
    mTimeout = 0; mSticky = 0; mCount = 0; mAdr = '0;
    sys_rst = 1; enable_i = 1; err_clr_i = 0; m_cyc_i = 0; m_stb_i = 0; m_we_i = 0;
    m_cti_i = '0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0; s_dat_i = '0; s_ack_i = 0;
    repeat (2) @(posedge sys_clk);
    #1;

    buildTable();
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].in);
      checkOutput($sformatf("tbl%0d_ack", i), obsAck, tbl[i].expAck);
      checkOutput($sformatf("tbl%0d_dat", i), obsDat, tbl[i].expDat);
      checkOutput($sformatf("tbl%0d_scyc", i), obsScyc, tbl[i].expScyc);
      checkOutput($sformatf("tbl%0d_to", i), obsTo, tbl[i].expTo);
      checkOutput($sformatf("tbl%0d_sticky", i), obsSticky, tbl[i].expSticky);
      checkOutput($sformatf("tbl%0d_cnt", i), obsCount, tbl[i].expCnt);
    end
    checkOutput("err_adr_logged", err_adr_o, 32'h6000_0010);

    // Four-beat burst with three wait states per beat: never times out.
    acks = 0; toSeen = 0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        s = mk(0, 1, 0, 1, 1, (k == 3), 32'h3000_0000 + 4 * b, 32'h111 * (b + 1));
        s.cti = (b == 3) ? CTI_EOB : 3'b010;
        applyStimulus(s);
        if (obsAck) begin
          acks++;
          checkOutput("burst_dat", obsDat, 32'h111 * (b + 1));
        end
        if (obsTo) toSeen++;
      end
    end
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    checkOutput("burst_acks", acks, 4);
    checkOutput("burst_timeouts", toSeen + obsTo, 0);
    checkOutput("burst_errcnt", obsCount, 0);

    // Back-to-back timeouts saturate the fault counter.
    forcedSeen = 0;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k <= TIMEOUT + 1; k++) begin
        applyStimulus(mk(0, 1, 0, 1, 1, 0, 32'h6000_0000 + i, i));
        if (obsAck && obsDat == ERR) forcedSeen++;
      end
    end
    checkOutput("sat_forced", forcedSeen, 300);
    checkOutput("sat_count", obsCount, 8'hff);

    // Clear in the same cycle as a forced ack: the timeout wins.
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    for (int k = 0; k <= TIMEOUT; k++)
      applyStimulus(mk(0, 1, (k == TIMEOUT), 1, 1, 0, 32'h6100_0000, 32'h5));
    checkOutput("clr_race_ack", obsAck, 1'b1);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    checkOutput("clr_race_count", obsCount, 8'd1);
    checkOutput("clr_race_sticky", obsSticky, 1'b1);

    // Watchdog disabled with a hung slave: no ack, ever.
    acks = 0;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(mk(0, 0, 0, 1, 1, 0, 32'h6200_0000, 32'h0));
      if (obsAck) acks++;
    end
    checkOutput("disabled_acks", acks, 0);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h0));

    // Reset while waiting at count 3; the held strobe is re-timed from 0.
    for (int k = 0; k < 3; k++)
      applyStimulus(mk(0, 1, 0, 1, 1, 0, 32'h7000_0000, k));
    applyStimulus(mk(1, 1, 0, 1, 1, 0, 32'h7000_0000, 32'h3));
    checkOutput("rst_noack", obsAck, 1'b0);
    ackAt = -1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(mk(0, 1, 0, 1, 1, 0, 32'h7000_0000, 32'h10 + k));
      if (obsAck && ackAt < 0) ackAt = k;
    end
    checkOutput("rst_retime", ackAt, 4);

    // Random traffic against the reference model.
    holdReq = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) holdReq = ~holdReq;
      s = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
             ($urandom_range(0, 29) == 0), holdReq,
             holdReq && ($urandom_range(0, 15) != 0), ($urandom_range(0, 6) == 0),
             $urandom, $urandom);
      s.cti = 3'($urandom_range(0, 7));
      s.sel = 4'($urandom_range(0, 15));
      applyStimulus(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
